// File: rtl/alu.sv
// 16-bit datapath ALU: combinational ADD/SUB/AND/NOT-B result and zero flag, plus a clocked
// status register {V, N, Z_q}; defining ALU_CARRY_FLAG_EN widens it to {C, V, N, Z_q}.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       ALUop,
    input  logic             status_en,
    output logic [WIDTH-1:0] out,
    output logic             Z,
`ifdef ALU_CARRY_FLAG_EN
    output logic [3:0]       status
`else
    output logic [2:0]       status
`endif
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_AND   = 2'b10,
        OP_NOT_B = 2'b11
    } alu_op_e;

    localparam int MSB = WIDTH - 1;

    logic v_flag;
    logic n_flag;

`ifdef ALU_CARRY_FLAG_EN
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;
    logic           c_flag;

    assign add_ext = {1'b0, Ain} + {1'b0, Bin};
    assign sub_ext = {1'b0, Ain} - {1'b0, Bin};
`endif

    // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
    always_comb begin
        out    = '0;
        v_flag = 1'b0;
`ifdef ALU_CARRY_FLAG_EN
        c_flag = 1'b0;
`endif
        case (alu_op_e'(ALUop))
            OP_ADD: begin
                out    = Ain + Bin;
                v_flag = (Ain[MSB] == Bin[MSB]) && (out[MSB] != Ain[MSB]);
`ifdef ALU_CARRY_FLAG_EN
                c_flag = add_ext[WIDTH];
`endif
            end
            OP_SUB: begin
                out    = Ain - Bin;
                v_flag = (Ain[MSB] != Bin[MSB]) && (out[MSB] != Ain[MSB]);
`ifdef ALU_CARRY_FLAG_EN
                // Carry is the inverted borrow, i.e. set when Ain >= Bin unsigned.
                c_flag = ~sub_ext[WIDTH];
`endif
            end
            OP_AND:   out = Ain & Bin;
            OP_NOT_B: out = ~Bin;
            default:  out = '0;
        endcase
    end

    assign Z      = (out == '0);
    assign n_flag = out[MSB];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (status_en) begin
`ifdef ALU_CARRY_FLAG_EN
            status <= {c_flag, v_flag, n_flag, Z};
`else
            status <= {v_flag, n_flag, Z};
`endif
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed result/flag vectors, status hold,
// asynchronous reset behaviour; carry flag checked when ALU_CARRY_FLAG_EN is defined.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [1:0]  ALUop;
    logic        status_en;
    logic [15:0] out;
    logic        Z;
`ifdef ALU_CARRY_FLAG_EN
    logic [3:0]  status;
`else
    logic [2:0]  status;
`endif

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .status_en (status_en),
        .out       (out),
        .Z         (Z),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                         input logic en);
        @(negedge clk);
        Ain       = a;
        Bin       = b;
        ALUop     = op;
        status_en = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        z;
        logic [2:0]  st;
        logic        c;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs = '{
            '{16'hE3AD, 16'h438B, 2'b00, 16'h2738, 1'b0, 3'b000, 1'b1},
            '{16'hE3AD, 16'h438B, 2'b01, 16'hA022, 1'b0, 3'b010, 1'b1},
            '{16'hE3AD, 16'h438B, 2'b10, 16'h4389, 1'b0, 3'b000, 1'b0},
            '{16'hE3AD, 16'h438B, 2'b11, 16'hBC74, 1'b0, 3'b010, 1'b0},
            '{16'h1234, 16'h1234, 2'b01, 16'h0000, 1'b1, 3'b001, 1'b1},
            '{16'h8000, 16'h0001, 2'b01, 16'h7FFF, 1'b0, 3'b100, 1'b1},
            '{16'hF0F0, 16'h0F0F, 2'b10, 16'h0000, 1'b1, 3'b001, 1'b0},
            '{16'h5555, 16'hFFFF, 2'b11, 16'h0000, 1'b1, 3'b001, 1'b0},
            '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 3'b001, 1'b1},
            '{16'h7FFF, 16'h0001, 2'b00, 16'h8000, 1'b0, 3'b110, 1'b0}
        };

        rst_n     = 1'b0;
        status_en = 1'b1;
        Ain       = 16'h7FFF;
        Bin       = 16'h0001;
        ALUop     = 2'b00;
        repeat (2) tick();
        check("reset_status", 32'(status), 32'h0);
        check("reset_out_comb", 32'(out), 32'h8000);

        @(negedge clk);
        rst_n = 1'b1;
        status_en = 1'b0;
        tick();
        check("release_no_en", 32'(status), 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            check($sformatf("out_%0d", i), 32'(out), 32'(vecs[i].res));
            check($sformatf("z_%0d", i), 32'(Z), 32'(vecs[i].z));
            tick();
            check($sformatf("status_%0d", i), 32'(status[2:0]), 32'(vecs[i].st));
`ifdef ALU_CARRY_FLAG_EN
            check($sformatf("carry_%0d", i), 32'(status[3]), 32'(vecs[i].c));
`endif
        end

        // Status must hold with status_en low even though the flags would change.
        drive(16'h1234, 16'h1234, 2'b01, 1'b0);
        check("hold_out", 32'(out), 32'h0);
        check("hold_z", 32'(Z), 32'h1);
        repeat (2) tick();
        check("hold_status", 32'(status[2:0]), 32'h6);

        // Mid-cycle asynchronous reset, with status_en high throughout.
        drive(16'h7FFF, 16'h0001, 2'b00, 1'b1);
        tick();
        check("pre_reset_status", 32'(status[2:0]), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_status", 32'(status), 32'h0);
        check("async_reset_out", 32'(out), 32'h8000);
        tick();
        check("reset_ignores_en", 32'(status), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_before_edge", 32'(status), 32'h0);
        tick();
        check("release_after_edge", 32'(status[2:0]), 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
